hammer_judge: RTL



---
 rtl/hammer_judge.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hammer_judge.sv
// Player-side judge: debounces keypad strikes, matches them against mole slots,
// and keeps score/combo/misses/lives under an IDLE/PLAY/OVER game FSM. Macro: COMBO_BONUS_EN.
module hammer_judge #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [3:0]  INIT_LIVES      = 4'd5,
    parameter logic [7:0]  COMBO_TH        = 8'd10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  keys,
    input  logic [19:0] moles,
    input  logic        survival,
    input  logic        start,
    output logic [4:0]  kill_list,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  miss_cnt,
    output logic [3:0]  lives,
    output logic        game_over
);

    localparam int unsigned N_HOLES = 9;
    localparam int unsigned N_SLOTS = 5;
    localparam int unsigned SLOT_W  = 4;
    localparam int unsigned CNT_W   = 20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    logic [N_HOLES-1:0] r_sync1;
    logic [N_HOLES-1:0] r_sync2;
    logic [N_HOLES-1:0] r_deb;
    logic [N_HOLES-1:0] r_deb_d;
    logic [CNT_W-1:0]   r_cnt [N_HOLES];

    state_t             r_state;
    logic [N_SLOTS-1:0] r_kill_list;
    logic [15:0]        r_score;
    logic [7:0]         r_combo;
    logic [7:0]         r_miss_cnt;
    logic [3:0]         r_lives;
    logic               r_game_over;

    logic [N_HOLES-1:0] w_strike;
    logic [N_HOLES-1:0] w_matched;
    logic [N_SLOTS-1:0] w_hit;
    logic [2:0]         w_kills;
    logic [3:0]         w_misses;
    logic [3:0]         w_gain;
    logic [16:0]        w_score_sum;
    logic [8:0]         w_combo_sum;
    logic [8:0]         w_miss_sum;
    logic [15:0]        w_score_sat;
    logic [7:0]         w_combo_sat;
    logic [7:0]         w_miss_sat;

    // Synchronize and debounce every key; runs regardless of game state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int h = 0; h < N_HOLES; h++) begin
                r_cnt[h] <= '0;
            end
        end else begin
            r_sync1 <= keys;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int h = 0; h < N_HOLES; h++) begin
                if (r_sync2[h] == r_deb[h]) begin
                    r_cnt[h] <= '0;
                end else if (r_cnt[h] == DEBOUNCE_CYCLES - 20'd1) begin
                    r_deb[h] <= r_sync2[h];
                    r_cnt[h] <= '0;
                end else begin
                    r_cnt[h] <= r_cnt[h] + CNT_W'(1);
                end
            end
        end
    end

    assign w_strike = r_deb & ~r_deb_d;

    // Slot/hole matching; slot locations 9..15 can never equal a hole index.
    always_comb begin
        w_hit     = '0;
        w_matched = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            for (int h = 0; h < N_HOLES; h++) begin
                if (moles[SLOT_W*i +: SLOT_W] == SLOT_W'(h) && w_strike[h]) begin
                    w_hit[i]     = 1'b1;
                    w_matched[h] = 1'b1;
                end
            end
        end
        w_kills = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_kills = w_kills + 3'(w_hit[i]);
        end
        w_misses = '0;
        for (int h = 0; h < N_HOLES; h++) begin
            w_misses = w_misses + 4'(w_strike[h] & ~w_matched[h]);
        end
    end

`ifdef COMBO_BONUS_EN
    assign w_gain = (r_combo >= COMBO_TH) ? {w_kills, 1'b0} : {1'b0, w_kills};
`else
    logic w_unused_combo_th;
    assign w_unused_combo_th = ^COMBO_TH;
    assign w_gain = {1'b0, w_kills};
`endif

    assign w_score_sum = 17'(r_score) + 17'(w_gain);
    assign w_combo_sum = 9'(r_combo) + 9'(w_kills);
    assign w_miss_sum  = 9'(r_miss_cnt) + 9'(w_misses);
    assign w_score_sat = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    assign w_combo_sat = w_combo_sum[8] ? 8'hFF : w_combo_sum[7:0];
    assign w_miss_sat  = w_miss_sum[8] ? 8'hFF : w_miss_sum[7:0];

    // Game FSM with registered outputs; start wins over everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_kill_list <= '0;
            r_score     <= '0;
            r_combo     <= '0;
            r_miss_cnt  <= '0;
            r_lives     <= INIT_LIVES;
            r_game_over <= 1'b0;
        end else begin
            r_kill_list <= '0;
            if (start) begin
                r_state     <= S_PLAY;
                r_score     <= '0;
                r_combo     <= '0;
                r_miss_cnt  <= '0;
                r_lives     <= INIT_LIVES;
                r_game_over <= 1'b0;
            end else begin
                case (r_state)
                    S_PLAY: begin
                        r_kill_list <= w_hit;
                        r_score     <= w_score_sat;
                        r_miss_cnt  <= w_miss_sat;
                        r_combo     <= (w_misses != 4'd0 || survival) ? 8'd0 : w_combo_sat;
                        if (survival) begin
                            r_lives <= (r_lives == 4'd0) ? 4'd0 : r_lives - 4'd1;
                            if (r_lives == 4'd1) begin
                                r_state     <= S_OVER;
                                r_game_over <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign kill_list = r_kill_list;
    assign score     = r_score;
    assign combo     = r_combo;
    assign miss_cnt  = r_miss_cnt;
    assign lives     = r_lives;
    assign game_over = r_game_over;

endmodule
